// File: rtl/cps2_pattern_gen.sv
// CPS2 native video source: fixed raster, four test patterns; all outputs registered (latency 1), free-running, no backpressure.
// Optional FADE_SWEEP_EN: F_out in the active window sweeps 1..15,0 once per frame instead of a constant 4'hF.
module cps2_pattern_gen #(
   parameter int H_TOTAL     = 512,
   parameter int H_SYNCLEN   = 36,
   parameter int H_BACKPORCH = 62,
   parameter int H_ACTIVE    = 384,
   parameter int V_TOTAL     = 262,
   parameter int V_SYNCLEN   = 3,
   parameter int V_BACKPORCH = 28,
   parameter int V_ACTIVE    = 224
) (
   input  logic        PCLK_in,
   input  logic        reset_n,
   input  logic        enable,
   input  logic [1:0]  pattern_sel,
   input  logic [11:0] fg_color,
   output logic [3:0]  R_out,
   output logic [3:0]  G_out,
   output logic [3:0]  B_out,
   output logic [3:0]  F_out,
   output logic        HSYNC_out,
   output logic        VSYNC_out,
   output logic        DE_out,
   output logic        frame_start,
   output logic [7:0]  frame_cnt
);

   localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0] H_SYNC    = 10'(H_SYNCLEN);
   localparam logic [9:0] H_ST      = 10'(H_SYNCLEN + H_BACKPORCH);
   localparam logic [9:0] H_EN      = 10'(H_SYNCLEN + H_BACKPORCH + H_ACTIVE);
   localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
   localparam logic [9:0] V_SYNC    = 10'(V_SYNCLEN);
   localparam logic [9:0] V_ST      = 10'(V_SYNCLEN + V_BACKPORCH);
   localparam logic [9:0] V_EN      = 10'(V_SYNCLEN + V_BACKPORCH + V_ACTIVE);
   localparam logic [5:0] BAR_LAST  = 6'd47;
   localparam logic [9:0] STEP_LAST = 10'(H_ACTIVE / 16 - 1);

   logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
   logic [2:0]  bar_q, bar_d;
   logic [5:0]  bar_px_q, bar_px_d;
   logic [3:0]  step_q, step_d;
   logic [9:0]  step_px_q, step_px_d;
   logic        en_sh_q, en_sh_d;
   logic [1:0]  pat_sh_q, pat_sh_d;
   logic [11:0] fg_sh_q, fg_sh_d;
   logic [11:0] rgb_q, rgb_d;
   logic [3:0]  f_q, f_d;
   logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
   logic [7:0]  fc_q, fc_d;

   logic        frame_first, h_act, v_act, act;
   logic [3:0]  x_lo, y_lo, f_act;
   logic [11:0] pix;

   assign frame_first = (hcnt_q == 10'd0) && (vcnt_q == 10'd0);
   assign h_act       = (hcnt_q >= H_ST) && (hcnt_q < H_EN);
   assign v_act       = (vcnt_q >= V_ST) && (vcnt_q < V_EN);
   assign act         = h_act && v_act;
   // Only bit 3 of the active-window position matters for the checkerboard.
   assign x_lo        = hcnt_q[3:0] - H_ST[3:0];
   assign y_lo        = vcnt_q[3:0] - V_ST[3:0];

`ifdef FADE_SWEEP_EN
   logic [3:0] fade_q, fade_d;

   assign fade_d = frame_first ? fade_q + 4'd1 : fade_q;
   assign f_act  = fade_q;

   always_ff @(posedge PCLK_in) begin
      if (!reset_n) fade_q <= 4'd0;
      else          fade_q <= fade_d;
   end
`else
   assign f_act = 4'hF;
`endif

   always_comb begin
      pix = 12'h000;
      case (pat_sh_q)
         2'd0:    pix = fg_sh_q;
         2'd1:    pix = {{4{~bar_q[1]}}, {4{~bar_q[2]}}, {4{~bar_q[0]}}};
         2'd2:    pix = {step_q, step_q, step_q};
         default: pix = {12{x_lo[3] ^ y_lo[3]}};
      endcase
   end

   always_comb begin
      hcnt_d    = hcnt_q + 10'd1;
      vcnt_d    = vcnt_q;
      bar_d     = 3'd0;
      bar_px_d  = 6'd0;
      step_d    = 4'd0;
      step_px_d = 10'd0;
      en_sh_d   = en_sh_q;
      pat_sh_d  = pat_sh_q;
      fg_sh_d   = fg_sh_q;
      fc_d      = fc_q;

      if (hcnt_q == H_LAST) begin
         hcnt_d = 10'd0;
         vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
      end

      // Bar and ramp position are tracked by counters cleared outside the active span.
      if (h_act) begin
         bar_d     = bar_q;
         step_d    = step_q;
         bar_px_d  = bar_px_q + 6'd1;
         step_px_d = step_px_q + 10'd1;
         if (bar_px_q == BAR_LAST) begin
            bar_px_d = 6'd0;
            bar_d    = bar_q + 3'd1;
         end
         if (step_px_q == STEP_LAST) begin
            step_px_d = 10'd0;
            step_d    = step_q + 4'd1;
         end
      end

      if (frame_first) begin
         en_sh_d  = enable;
         pat_sh_d = pattern_sel;
         fg_sh_d  = fg_color;
         fc_d     = fc_q + 8'd1;
      end

      fs_d  = frame_first;
      hs_d  = ~(hcnt_q < H_SYNC);
      vs_d  = ~(vcnt_q < V_SYNC);
      de_d  = act;
      rgb_d = 12'h000;
      f_d   = 4'h0;
      if (act && en_sh_q) begin
         rgb_d = pix;
         f_d   = f_act;
      end
   end

   always_ff @(posedge PCLK_in) begin
      if (!reset_n) begin
         hcnt_q    <= 10'd0;
         vcnt_q    <= 10'd0;
         bar_q     <= 3'd0;
         bar_px_q  <= 6'd0;
         step_q    <= 4'd0;
         step_px_q <= 10'd0;
         en_sh_q   <= 1'b0;
         pat_sh_q  <= 2'd0;
         fg_sh_q   <= 12'h000;
         rgb_q     <= 12'h000;
         f_q       <= 4'h0;
         hs_q      <= 1'b1;
         vs_q      <= 1'b1;
         de_q      <= 1'b0;
         fs_q      <= 1'b0;
         fc_q      <= 8'd0;
      end else begin
         hcnt_q    <= hcnt_d;
         vcnt_q    <= vcnt_d;
         bar_q     <= bar_d;
         bar_px_q  <= bar_px_d;
         step_q    <= step_d;
         step_px_q <= step_px_d;
         en_sh_q   <= en_sh_d;
         pat_sh_q  <= pat_sh_d;
         fg_sh_q   <= fg_sh_d;
         rgb_q     <= rgb_d;
         f_q       <= f_d;
         hs_q      <= hs_d;
         vs_q      <= vs_d;
         de_q      <= de_d;
         fs_q      <= fs_d;
         fc_q      <= fc_d;
      end
   end

   assign R_out       = rgb_q[11:8];
   assign G_out       = rgb_q[7:4];
   assign B_out       = rgb_q[3:0];
   assign F_out       = f_q;
   assign HSYNC_out   = hs_q;
   assign VSYNC_out   = vs_q;
   assign DE_out      = de_q;
   assign frame_start = fs_q;
   assign frame_cnt   = fc_q;

endmodule

// File: tb/tb_cps2_pattern_gen.sv
// Directed bench for cps2_pattern_gen: real horizontal timing, shortened vertical raster.
module tb_cps2_pattern_gen;

   localparam int HT    = 512;
   localparam int HSL   = 36;
   localparam int HBP   = 62;
   localparam int HA    = 384;
   localparam int VT    = 14;
   localparam int VSL   = 3;
   localparam int VBP   = 2;
   localparam int VA    = 9;
   localparam int H_ST  = HSL + HBP;
   localparam int V_ST  = VSL + VBP;
   localparam int FRAME = HT * VT;

   logic        PCLK_in = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b0;
   logic [1:0]  pattern_sel = 2'd0;
   logic [11:0] fg_color = 12'h000;
   logic [3:0]  R_out, G_out, B_out, F_out;
   logic        HSYNC_out, VSYNC_out, DE_out, frame_start;
   logic [7:0]  frame_cnt;
   logic [11:0] rgb;

   int n_cmp = 0;
   int n_err = 0;
   int pos   = -1;   // counter state shown on the outputs, in cycles since the first edge after release

   assign rgb = {R_out, G_out, B_out};

   always #5 PCLK_in = ~PCLK_in;

   cps2_pattern_gen #(
      .H_TOTAL(HT), .H_SYNCLEN(HSL), .H_BACKPORCH(HBP), .H_ACTIVE(HA),
      .V_TOTAL(VT), .V_SYNCLEN(VSL), .V_BACKPORCH(VBP), .V_ACTIVE(VA)
   ) dut (
      .PCLK_in(PCLK_in), .reset_n(reset_n), .enable(enable),
      .pattern_sel(pattern_sel), .fg_color(fg_color),
      .R_out(R_out), .G_out(G_out), .B_out(B_out), .F_out(F_out),
      .HSYNC_out(HSYNC_out), .VSYNC_out(VSYNC_out), .DE_out(DE_out),
      .frame_start(frame_start), .frame_cnt(frame_cnt)
   );

   function automatic int pix_pos(input int f, input int h, input int v);
      return f * FRAME + v * HT + h;
   endfunction

   // Expected active-window fade for the n-th frame after reset (1-based).
   function automatic logic [3:0] f_exp(input int frame);
      logic [3:0] r;
      r = 4'(frame % 16);
`ifndef FADE_SWEEP_EN
      r = 4'hF;
`endif
      return r;
   endfunction

   task automatic tick();
      @(negedge PCLK_in);
      pos = pos + 1;
   endtask

   task automatic run_to(input int target);
      while (pos < target) tick();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (4) @(negedge PCLK_in);
      n_cmp++; if (HSYNC_out !== 1'b1) begin n_err++; $display("FAIL reset_hsync: got %b want 1", HSYNC_out); end
      n_cmp++; if (VSYNC_out !== 1'b1) begin n_err++; $display("FAIL reset_vsync: got %b want 1", VSYNC_out); end
      n_cmp++; if (DE_out !== 1'b0) begin n_err++; $display("FAIL reset_de: got %b want 0", DE_out); end
      n_cmp++; if (rgb !== 12'h000) begin n_err++; $display("FAIL reset_rgb: got %h want 000", rgb); end
      n_cmp++; if (F_out !== 4'h0) begin n_err++; $display("FAIL reset_f: got %h want 0", F_out); end
      n_cmp++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL reset_fs: got %b want 0", frame_start); end
      n_cmp++; if (frame_cnt !== 8'd0) begin n_err++; $display("FAIL reset_fcnt: got %0d want 0", frame_cnt); end
      enable      = 1'b1;
      pattern_sel = 2'd2;
      fg_color    = 12'h000;
      reset_n     = 1'b1;
      pos         = -1;
   endtask

   // Frame 1: raster timing counts plus grey ramp; a mid-frame switch to bars must not show.
   task automatic test_raster_ramp();
      int hs_low, vs_low, de_hi, fs_n, first_de;
      hs_low = 0; vs_low = 0; de_hi = 0; fs_n = 0; first_de = -1;
      run_to(0);
      repeat (FRAME) begin
         if (!HSYNC_out) hs_low++;
         if (!VSYNC_out) vs_low++;
         if (DE_out) de_hi++;
         if (frame_start) fs_n++;
         if (DE_out && first_de < 0) first_de = pos;
         if (pos == 0) begin
            n_cmp++; if (frame_start !== 1'b1) begin n_err++; $display("FAIL first_fs: got %b want 1", frame_start); end
            n_cmp++; if (frame_cnt !== 8'd1) begin n_err++; $display("FAIL first_fcnt: got %0d want 1", frame_cnt); end
         end
         if (pos == pix_pos(0, H_ST - 1, V_ST)) begin
            n_cmp++; if (rgb !== 12'h000 || DE_out !== 1'b0) begin n_err++; $display("FAIL pre_window: rgb %h de %b want 000/0", rgb, DE_out); end
         end
         if (pos == pix_pos(0, H_ST, V_ST)) begin
            n_cmp++; if (rgb !== 12'h000) begin n_err++; $display("FAIL ramp_x0: got %h want 000", rgb); end
            n_cmp++; if (F_out !== f_exp(1)) begin n_err++; $display("FAIL fade_frame1: got %h want %h", F_out, f_exp(1)); end
         end
         if (pos == pix_pos(0, H_ST + 23, V_ST)) begin
            n_cmp++; if (rgb !== 12'h000) begin n_err++; $display("FAIL ramp_x23: got %h want 000", rgb); end
         end
         if (pos == pix_pos(0, H_ST + 24, V_ST)) begin
            n_cmp++; if (rgb !== 12'h111) begin n_err++; $display("FAIL ramp_x24: got %h want 111", rgb); end
         end
         if (pos == pix_pos(0, H_ST + 383, V_ST)) begin
            n_cmp++; if (rgb !== 12'hFFF) begin n_err++; $display("FAIL ramp_x383: got %h want FFF", rgb); end
         end
         if (pos == pix_pos(0, H_ST + 384, V_ST)) begin
            n_cmp++; if (rgb !== 12'h000 || F_out !== 4'h0 || DE_out !== 1'b0) begin n_err++; $display("FAIL post_window: rgb %h f %h de %b want 000/0/0", rgb, F_out, DE_out); end
         end
         if (pos == pix_pos(0, 0, V_ST + 1)) pattern_sel = 2'd1;
         if (pos == pix_pos(0, H_ST + 24, V_ST + VA - 1)) begin
            n_cmp++; if (rgb !== 12'h111) begin n_err++; $display("FAIL ramp_held: got %h want 111", rgb); end
         end
         tick();
      end
      n_cmp++; if (hs_low !== HSL * VT) begin n_err++; $display("FAIL hsync_low: got %0d want %0d", hs_low, HSL * VT); end
      n_cmp++; if (vs_low !== VSL * HT) begin n_err++; $display("FAIL vsync_low: got %0d want %0d", vs_low, VSL * HT); end
      n_cmp++; if (de_hi !== HA * VA) begin n_err++; $display("FAIL de_count: got %0d want %0d", de_hi, HA * VA); end
      n_cmp++; if (first_de !== V_ST * HT + H_ST) begin n_err++; $display("FAIL first_de: got %0d want %0d", first_de, V_ST * HT + H_ST); end
      n_cmp++; if (fs_n !== 1) begin n_err++; $display("FAIL fs_per_frame: got %0d want 1", fs_n); end
   endtask

   // Frame 2: colour bars.
   task automatic test_colour_bars();
      int          xs [10] = '{0, 47, 48, 96, 144, 192, 240, 288, 336, 383};
      logic [11:0] ex [10] = '{12'hFFF, 12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                               12'hF0F, 12'hF00, 12'h00F, 12'h000, 12'h000};
      run_to(pix_pos(1, 0, 0));
      n_cmp++; if (frame_start !== 1'b1 || frame_cnt !== 8'd2) begin n_err++; $display("FAIL frame2_start: fs %b cnt %0d want 1/2", frame_start, frame_cnt); end
      for (int i = 0; i < 10; i++) begin
         run_to(pix_pos(1, H_ST + xs[i], V_ST + 2));
         n_cmp++; if (rgb !== ex[i]) begin n_err++; $display("FAIL bars_x%0d: got %h want %h", xs[i], rgb, ex[i]); end
         n_cmp++; if (F_out !== f_exp(2)) begin n_err++; $display("FAIL bars_fade_x%0d: got %h want %h", xs[i], F_out, f_exp(2)); end
      end
      enable = 1'b0;
   endtask

   // Frame 3: enable latched low blanks colour but not timing.
   task automatic test_enable_off();
      int hs_low, vs_low, de_hi, nz;
      hs_low = 0; vs_low = 0; de_hi = 0; nz = 0;
      run_to(pix_pos(2, 0, 0));
      repeat (FRAME) begin
         if (!HSYNC_out) hs_low++;
         if (!VSYNC_out) vs_low++;
         if (DE_out) de_hi++;
         if (rgb !== 12'h000 || F_out !== 4'h0) nz++;
         if (pos == pix_pos(2, 0, 1)) begin
            enable      = 1'b1;
            pattern_sel = 2'd0;
            fg_color    = 12'hF00;
         end
         tick();
      end
      n_cmp++; if (nz !== 0) begin n_err++; $display("FAIL blank_pixels: got %0d nonzero want 0", nz); end
      n_cmp++; if (hs_low !== HSL * VT) begin n_err++; $display("FAIL off_hsync_low: got %0d want %0d", hs_low, HSL * VT); end
      n_cmp++; if (vs_low !== VSL * HT) begin n_err++; $display("FAIL off_vsync_low: got %0d want %0d", vs_low, VSL * HT); end
      n_cmp++; if (de_hi !== HA * VA) begin n_err++; $display("FAIL off_de_count: got %0d want %0d", de_hi, HA * VA); end
   endtask

   // Frame 4 solid F00 with a mid-frame switch to checkerboard; frame 5 shows the checkerboard.
   task automatic test_pattern_switch();
      int          cx [5] = '{0, 8, 7, 0, 8};
      int          cy [5] = '{0, 0, 7, 8, 8};
      logic [11:0] ce [5] = '{12'h000, 12'hFFF, 12'h000, 12'hFFF, 12'h000};
      run_to(pix_pos(3, H_ST, V_ST));
      n_cmp++; if (rgb !== 12'hF00) begin n_err++; $display("FAIL solid: got %h want F00", rgb); end
      run_to(pix_pos(3, 0, V_ST + 5));
      pattern_sel = 2'd3;
      run_to(pix_pos(3, H_ST + 8, V_ST + 5));
      n_cmp++; if (rgb !== 12'hF00) begin n_err++; $display("FAIL solid_held_y5: got %h want F00", rgb); end
      run_to(pix_pos(3, H_ST + 8, V_ST + 8));
      n_cmp++; if (rgb !== 12'hF00) begin n_err++; $display("FAIL solid_held_y8: got %h want F00", rgb); end
      run_to(pix_pos(4, 0, 0));
      n_cmp++; if (frame_cnt !== 8'd5) begin n_err++; $display("FAIL frame5_cnt: got %0d want 5", frame_cnt); end
      for (int i = 0; i < 5; i++) begin
         run_to(pix_pos(4, H_ST + cx[i], V_ST + cy[i]));
         n_cmp++; if (rgb !== ce[i]) begin n_err++; $display("FAIL checker_x%0d_y%0d: got %h want %h", cx[i], cy[i], rgb, ce[i]); end
      end
   endtask

   task automatic test_reset_midline();
      int extra;
      extra = 0;
      run_to(pix_pos(5, 199, V_ST + 1));
      n_cmp++; if (DE_out !== 1'b1) begin n_err++; $display("FAIL pre_reset_de: got %b want 1", DE_out); end
      reset_n = 1'b0;
      tick();
      n_cmp++; if (HSYNC_out !== 1'b1 || DE_out !== 1'b0) begin n_err++; $display("FAIL midreset_sync: hs %b de %b want 1/0", HSYNC_out, DE_out); end
      n_cmp++; if (frame_cnt !== 8'd0 || rgb !== 12'h000) begin n_err++; $display("FAIL midreset_state: cnt %0d rgb %h want 0/000", frame_cnt, rgb); end
      repeat (3) tick();
      reset_n = 1'b1;
      pos     = -1;
      run_to(0);
      n_cmp++; if (frame_start !== 1'b1 || frame_cnt !== 8'd1) begin n_err++; $display("FAIL rel_fs: fs %b cnt %0d want 1/1", frame_start, frame_cnt); end
      tick();
      while (pos < FRAME) begin
         if (frame_start) extra++;
         if (pos == pix_pos(0, H_ST, V_ST)) begin
            n_cmp++; if (F_out !== f_exp(1)) begin n_err++; $display("FAIL rel_fade: got %h want %h", F_out, f_exp(1)); end
         end
         tick();
      end
      n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL fs_between: got %0d pulses want 0", extra); end
      n_cmp++; if (frame_start !== 1'b1 || frame_cnt !== 8'd2) begin n_err++; $display("FAIL fs_interval: fs %b cnt %0d want 1/2", frame_start, frame_cnt); end
   endtask

   initial begin
      test_reset();
      test_raster_ramp();
      test_colour_bars();
      test_enable_off();
      test_pattern_switch();
      test_reset_midline();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
